// File: rtl/interval_timer.sv
// Countdown timer: fetches a duration from the time-parameter store,
// counts it down in seconds and pulses expired at the end.
module interval_timer #(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic       clk,
    input  logic       reset_sync,
    input  logic       start,
    input  logic [1:0] int_sel,
    input  logic       cancel,
    input  logic [3:0] tp_val,
    output logic [1:0] interval,
    output logic       busy,
    output logic       expired,
    output logic [3:0] remaining
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PS_MAX = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        COUNT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] prescaler;
    logic          accept;
    logic          tick;
    logic          busy_nxt;
    logic          expired_nxt;

    assign accept = start && (int_sel != 2'b11);
    assign tick   = (state == COUNT) && (prescaler == PS_MAX);

    always_ff @(posedge clk) begin
        if (reset_sync) begin
            state   <= IDLE;
            busy    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_nxt;
            busy    <= busy_nxt;
            expired <= expired_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = REQ;
            REQ:     state_nxt = cancel ? IDLE : LOAD;
            LOAD:    state_nxt = cancel ? IDLE : COUNT;
            COUNT: begin
                if (cancel)
                    state_nxt = IDLE;
                else if (tick && remaining == 4'd1)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = accept ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // busy/expired are decoded from the next state so they leave a flop
    always_comb begin
        busy_nxt    = 1'b0;
        expired_nxt = 1'b0;
        unique case (state_nxt)
            REQ, LOAD, COUNT: busy_nxt = 1'b1;
            DONE:             expired_nxt = 1'b1;
            default:          ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_sync) begin
            interval  <= 2'b00;
            remaining <= 4'd0;
            prescaler <= '0;
        end else begin
            if ((state == IDLE || state == DONE) && accept)
                interval <= int_sel;
            unique case (state)
                REQ: begin
                    if (cancel) begin
                        remaining <= 4'd0;
                        prescaler <= '0;
                    end
                end
                LOAD: begin
                    prescaler <= '0;
                    if (cancel)
                        remaining <= 4'd0;
                    else
                        remaining <= (tp_val == 4'd0) ? 4'd1 : tp_val;
                end
                COUNT: begin
                    if (cancel) begin
                        remaining <= 4'd0;
                        prescaler <= '0;
                    end else if (tick) begin
                        prescaler <= '0;
                        remaining <= remaining - 4'd1;
                    end else begin
                        prescaler <= prescaler + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_interval_timer.sv
// Scoreboarded random test of interval_timer against an
// arithmetic model of when each countdown should expire.
module tb_interval_timer;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset_sync = 1'b1;
    logic       start = 1'b0;
    logic [1:0] int_sel = 2'b00;
    logic       cancel = 1'b0;
    logic [3:0] tp_val = 4'd0;
    logic [1:0] interval;
    logic       busy;
    logic       expired;
    logic [3:0] remaining;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [3:0] tp_tab [4];
    logic [1:0] exp_int = 2'b00;
    int         exp_q [$];

    interval_timer #(.TICKS_PER_SEC(T)) dut (
        .clk       (clk),
        .reset_sync(reset_sync),
        .start     (start),
        .int_sel   (int_sel),
        .cancel    (cancel),
        .tp_val    (tp_val),
        .interval  (interval),
        .busy      (busy),
        .expired   (expired),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // time-parameter store: one registered cycle after interval
    always @(posedge clk) tp_val <= tp_tab[interval];

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d",
                     name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0 && cyc > exp_q[0]) begin
            tests++;
            fails++;
            $display("FAIL expire_missing: expected at %0d, now %0d",
                     exp_q[0], cyc);
            void'(exp_q.pop_front());
        end
        if (expired) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL expire_unexpected at cycle %0d", cyc);
            end else begin
                check("expire_cycle", cyc, exp_q.pop_front());
            end
        end
    end

    // Called at a negedge where the DUT is in IDLE or DONE.
    // mode: 0 normal, 1 cancel, 2 normal leaving DUT in DONE, 3 reset
    task automatic run_job(input logic [1:0] s, input int mode,
                           input int ofs, input bit reprog,
                           input bit start_busy);
        int e0, n, ed, k;
        start   = 1'b1;
        int_sel = s;
        e0      = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        if (s == 2'b11) begin
            check("ignored_busy", busy, 0);
            check("ignored_interval", interval, exp_int);
            return;
        end
        exp_int = s;
        check("busy_req", busy, 1);
        check("interval_set", interval, s);
        n  = (tp_tab[s] == 4'd0) ? 1 : int'(tp_tab[s]);
        ed = e0 + 2 + n * T;
        if (mode == 1 || mode == 3) begin
            k = e0 + 1 + (ofs % (ed - e0));
            while (cyc < k - 1) @(negedge clk);
            if (mode == 1) begin
                cancel  = 1'b1;
                start   = 1'($urandom % 2);
                int_sel = 2'($urandom % 3);
            end else begin
                reset_sync = 1'b1;
            end
            @(negedge clk);
            cancel     = 1'b0;
            start      = 1'b0;
            reset_sync = 1'b0;
            if (mode == 3) begin
                exp_int = 2'b00;
                check("reset_expired", expired, 0);
            end
            check("abort_busy", busy, 0);
            check("abort_remaining", remaining, 0);
            check("abort_interval", interval, exp_int);
            @(negedge clk);
            check("abort_stays_idle", busy, 0);
            return;
        end
        exp_q.push_back(ed);
        while (cyc < e0 + 2) @(negedge clk);
        check("remaining_load", remaining, n);
        if (reprog)
            tp_tab[s] = 4'(int'(tp_tab[s]) + 1 + int'($urandom % 14));
        if (start_busy) begin
            start   = 1'b1;
            int_sel = (s == 2'b01) ? 2'b10 : 2'b01;
            @(negedge clk);
            start = 1'b0;
            check("start_ignored_busy", interval, s);
        end
        while (cyc < ed) @(negedge clk);
        check("busy_done", busy, 0);
        check("remaining_done", remaining, 0);
        if (mode != 2) begin
            @(negedge clk);
            check("idle_after_done", busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tp_tab[0] = 4'd6;
        tp_tab[1] = 4'd3;
        tp_tab[2] = 4'd0;
        tp_tab[3] = 4'd5;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_expired", expired, 0);
        check("reset_remaining", remaining, 0);
        check("reset_interval", interval, 0);
        reset_sync = 1'b0;
        @(negedge clk);

        run_job(2'b00, 0, 0, 1'b0, 1'b0);
        run_job(2'b10, 0, 0, 1'b0, 1'b0);
        run_job(2'b11, 0, 0, 1'b0, 1'b0);
        tp_tab[0] = 4'd3;
        run_job(2'b00, 1, 6, 1'b0, 1'b0);
        run_job(2'b00, 1, 9, 1'b0, 1'b0);
        tp_tab[0] = 4'd6;
        run_job(2'b00, 2, 0, 1'b0, 1'b0);
        run_job(2'b01, 0, 0, 1'b0, 1'b0);
        run_job(2'b00, 0, 0, 1'b1, 1'b1);

        for (int j = 0; j < 30; j++) begin
            logic [1:0] s;
            int         m;
            s = 2'($urandom % 4);
            if ($urandom % 2 == 0)
                tp_tab[s] = 4'($urandom % 16);
            m = int'($urandom % 3);
            run_job(s, m, int'($urandom % 64),
                    1'($urandom % 2), 1'($urandom % 2));
        end

        tp_tab[1] = 4'd5;
        run_job(2'b01, 3, 9, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
